key_tone: RTL and testbench

Downstream consumer of the matrix-keypad scanner. Takes the scanner's 4-bit key code stream and filters out scan-cycle flicker and glitches. Holds the last valid key through the scanner's idle samples, maps keys 1..15 to a 15-note scale (C4..C6), and drives a square-wave tone output for the buzzer. Code 0 means "no key" and is never a note.

---
 rtl/key_tone_if.sv | 28 ++
 rtl/key_tone.sv | 189 ++++++++++++++++++
 tb/tb_key_tone.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/key_tone_if.sv
// Keypad-tone link: scanner key codes in, buzzer tone and note status out.
// Latency: n/a (signal bundle only).
// Backpressure: none; key codes are sampled every clock.
interface key_tone_if;
  logic [3:0] key_code;
  logic       tone;
  logic [3:0] note;
  logic       playing;
  logic       note_start;

  // Driver side (scanner / bench) produces key codes and observes the tone outputs.
  modport master (
    output key_code,
    input  tone,
    input  note,
    input  playing,
    input  note_start
  );

  // Tone generator side.
  modport slave (
    input  key_code,
    output tone,
    output note,
    output playing,
    output note_start
  );
endinterface

// File: rtl/key_tone.sv
// Key filter and tone generator: debounces scanner codes, holds the note, drives a square wave.
// Latency: note/playing/note_start update on the edge sampling the CONFIRM-th matching code.
// Backpressure: none; every clock samples key_code unconditionally.
module key_tone #(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned HOLD_CYC = 1_000_000,
  parameter int unsigned CONFIRM  = 4
) (
  input  logic         clk,
  input  logic         rst,
  key_tone_if.slave    kt
);

  // The lowest note (k = 1) has the longest half-period and sizes the phase counter.
  localparam int unsigned HALF_MAX = CLK_HZ / (2 * 262);
  localparam int PW = $clog2(HALF_MAX + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);
  // One spare count above CONFIRM lets a held key saturate without re-accepting.
  localparam int CW = $clog2(CONFIRM + 2);

  function automatic int unsigned note_hz(input int k);
    int unsigned f;
    case (k)
      1:       f = 262;
      2:       f = 294;
      3:       f = 330;
      4:       f = 349;
      5:       f = 392;
      6:       f = 440;
      7:       f = 494;
      8:       f = 523;
      9:       f = 587;
      10:      f = 659;
      11:      f = 698;
      12:      f = 784;
      13:      f = 880;
      14:      f = 988;
      15:      f = 1047;
      default: f = 262;
    endcase
    return f;
  endfunction

  // Half-period minus one per key code, folded to constants at elaboration.
  function automatic logic [15:0][PW-1:0] build_half_m1();
    logic [15:0][PW-1:0] t;
    t = '0;
    for (int k = 1; k < 16; k++) begin
      t[k] = PW'(CLK_HZ / (2 * note_hz(k)) - 1);
    end
    return t;
  endfunction

  localparam logic [15:0][PW-1:0] HALF_M1 = build_half_m1();

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cand_q, cand_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [PW-1:0]  phase_q, phase_d;
  logic           tone_q, tone_d;
  logic [3:0]     note_q, note_d;
  logic           start_q, start_d;

  logic           nz;
  logic           accept;
  logic           advance;

  // State and datapath registers; reset silences the buzzer without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      phase_q <= '0;
      tone_q  <= 1'b0;
      note_q  <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      phase_q <= phase_d;
      tone_q  <= tone_d;
      note_q  <= note_d;
      start_q <= start_d;
    end
  end

  // Candidate tracking, acceptance, hold/release and square-wave generation.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    phase_d = phase_q;
    tone_d  = tone_q;
    note_d  = note_q;
    start_d = 1'b0;
    advance = 1'b0;
    nz      = (kt.key_code != 4'd0);

    // Zero samples are scanner idle slots and never disturb the candidate.
    if (nz) begin
      if (kt.key_code == cand_q) begin
        if (cnt_q != CW'(CONFIRM + 1)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        cand_d = kt.key_code;
        cnt_d  = CW'(1);
      end
    end
    accept = nz && (cnt_d == CW'(CONFIRM));

    case (state_q)
      ST_IDLE: begin
        hold_d  = '0;
        phase_d = '0;
        tone_d  = 1'b0;
        note_d  = 4'd0;
        if (accept) begin
          state_d = ST_PLAY;
          note_d  = cand_d;
          hold_d  = HW'(HOLD_CYC);
          start_d = 1'b1;
        end
      end

      ST_PLAY: begin
        advance = 1'b1;
        if (nz) begin
          hold_d = HW'(HOLD_CYC);
          // Re-confirming the sounding key must not restart its waveform.
          if (accept && (cand_d != note_q)) begin
            note_d  = cand_d;
            phase_d = '0;
            tone_d  = 1'b0;
            start_d = 1'b1;
            advance = 1'b0;
          end
        end else if (hold_q <= HW'(1)) begin
          state_d = ST_IDLE;
          note_d  = 4'd0;
          tone_d  = 1'b0;
          phase_d = '0;
          hold_d  = '0;
          cand_d  = 4'd0;
          cnt_d   = '0;
          advance = 1'b0;
        end else begin
          hold_d = hold_q - HW'(1);
        end

        if (advance) begin
          if (phase_q >= HALF_M1[note_q]) begin
            phase_d = '0;
            tone_d  = ~tone_q;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cand_d  = 4'd0;
        cnt_d   = '0;
        hold_d  = '0;
        phase_d = '0;
        tone_d  = 1'b0;
        note_d  = 4'd0;
      end
    endcase
  end

  assign kt.tone       = tone_q;
  assign kt.note       = note_q;
  assign kt.playing    = (state_q == ST_PLAY);
  assign kt.note_start = start_q;

endmodule

// File: tb/tb_key_tone.sv
// Directed bench for key_tone: filtering, acceptance, tone timing, hold/release, note change, async reset.
// Latency: checks sample outputs 1 time unit after each active clock edge.
// Backpressure: none; one key code is driven per clock.
module tb_key_tone;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   acc;

  key_tone_if kif();

  key_tone #(
    .CLK_HZ   (52_400),
    .HOLD_CYC (16),
    .CONFIRM  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kt  (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one sample, let the next rising edge take it, then settle.
  task automatic cyc(input logic [3:0] code);
    kif.key_code = code;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    kif.key_code = 4'd0;

    // Reset state
    #12;
    chk("rst_tone", int'(kif.tone), 0);
    chk("rst_note", int'(kif.note), 0);
    chk("rst_playing", int'(kif.playing), 0);
    chk("rst_note_start", int'(kif.note_start), 0);
    #11;
    rst = 1'b1;

    // Idle: 200 zero samples produce nothing
    acc = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(4'd0);
      acc = acc | int'(kif.tone) | int'(kif.playing) | int'(kif.note_start) | int'(kif.note);
    end
    chk("idle_quiet", acc, 0);

    // Scanner pattern 1,0,1,0,1,0 then the 4th "1"
    for (int i = 0; i < 6; i++) cyc((i % 2 == 0) ? 4'd1 : 4'd0);
    chk("pre_accept_playing", int'(kif.playing), 0);
    cyc(4'd1);
    chk("acc1_note", int'(kif.note), 1);
    chk("acc1_playing", int'(kif.playing), 1);
    chk("acc1_note_start", int'(kif.note_start), 1);
    chk("acc1_tone", int'(kif.tone), 0);

    // Continue the pattern; tone rises 100 cycles after acceptance, period 200
    acc = 0;
    for (int k = 1; k <= 300; k++) begin
      cyc((k % 2 == 0) ? 4'd1 : 4'd0);
      if (k == 1)   chk("acc1_pulse_end", int'(kif.note_start), 0);
      if (k > 1)    acc = acc | int'(kif.note_start);
      if (k == 99)  chk("n1_tone_k99", int'(kif.tone), 0);
      if (k == 100) chk("n1_tone_k100", int'(kif.tone), 1);
      if (k == 199) chk("n1_tone_k199", int'(kif.tone), 1);
      if (k == 200) chk("n1_tone_k200", int'(kif.tone), 0);
      if (k == 300) chk("n1_tone_k300", int'(kif.tone), 1);
    end
    chk("n1_no_repulse", acc, 0);

    // Hold: 15 zeros keep playing, a "1" on the last hold cycle reloads
    for (int i = 0; i < 15; i++) cyc(4'd0);
    chk("hold15_playing", int'(kif.playing), 1);
    chk("hold15_note", int'(kif.note), 1);
    cyc(4'd1);
    chk("reload_playing", int'(kif.playing), 1);
    chk("reload_no_pulse", int'(kif.note_start), 0);
    for (int i = 0; i < 15; i++) cyc(4'd0);
    chk("rel15_playing", int'(kif.playing), 1);
    cyc(4'd0);
    chk("rel16_playing", int'(kif.playing), 0);
    chk("rel16_note", int'(kif.note), 0);
    chk("rel16_tone", int'(kif.tone), 0);

    // 6 x3 does not confirm; 2 x4 does
    for (int i = 0; i < 3; i++) cyc(4'd6);
    chk("six3_playing", int'(kif.playing), 0);
    for (int i = 0; i < 3; i++) cyc(4'd2);
    chk("two3_playing", int'(kif.playing), 0);
    cyc(4'd2);
    chk("two4_note", int'(kif.note), 2);
    chk("two4_note_start", int'(kif.note_start), 1);
    cyc(4'd0);
    chk("two_pulse_end", int'(kif.note_start), 0);
    for (int i = 0; i < 15; i++) cyc(4'd0);
    chk("two_released", int'(kif.playing), 0);

    // Note 1 held, then change to 6 in the middle of the high phase
    for (int i = 0; i < 4; i++) cyc(4'd1);
    chk("n1b_note", int'(kif.note), 1);
    for (int k = 1; k <= 150; k++) cyc(4'd1);
    chk("n1b_tone_high", int'(kif.tone), 1);
    for (int i = 0; i < 3; i++) cyc(4'd6);
    chk("six3_note_kept", int'(kif.note), 1);
    chk("six3_tone_kept", int'(kif.tone), 1);
    cyc(4'd6);
    chk("chg_note", int'(kif.note), 6);
    chk("chg_note_start", int'(kif.note_start), 1);
    chk("chg_tone_forced0", int'(kif.tone), 0);
    for (int j = 1; j <= 177; j++) begin
      cyc(4'd6);
      if (j == 1)   chk("chg_pulse_end", int'(kif.note_start), 0);
      if (j == 58)  chk("n6_tone_j58", int'(kif.tone), 0);
      if (j == 59)  chk("n6_tone_j59", int'(kif.tone), 1);
      if (j == 117) chk("n6_tone_j117", int'(kif.tone), 1);
      if (j == 118) chk("n6_tone_j118", int'(kif.tone), 0);
      if (j == 177) chk("n6_tone_j177", int'(kif.tone), 1);
    end

    // Asynchronous reset mid-tone, between clock edges
    #2;
    rst = 1'b0;
    #1;
    chk("arst_tone", int'(kif.tone), 0);
    chk("arst_note", int'(kif.note), 0);
    chk("arst_playing", int'(kif.playing), 0);
    chk("arst_note_start", int'(kif.note_start), 0);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cyc(4'd6);
    chk("post_rst_playing", int'(kif.playing), 0);
    chk("post_rst_tone", int'(kif.tone), 0);
    cyc(4'd6);
    chk("post_rst_accept", int'(kif.note), 6);
    chk("post_rst_playing2", int'(kif.playing), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
